// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame-capture sequencer.
package can_pkg;

  typedef enum logic [2:0] {
    IDLE_WAIT,
    IDLE,
    RECEIVE,
    TAIL,
    ERROR
  } state_t;

  localparam logic        RECESSIVE     = 1'b1;
  localparam logic        DOMINANT      = 1'b0;
  localparam int unsigned EOF_LEN       = 7;
  localparam int unsigned STUFF_LEN_DEF = 5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bit timing recovery: rx synchroniser, falling-edge detect, phase counter
// with resync-to-1 and the sample strobe at SAMPLE_PT.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 16,
  parameter int unsigned SAMPLE_PT   = 11
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_resync,
  output logic o_rx_s,
  output logic o_edge,
  output logic o_sample
);

  localparam int unsigned PW = $clog2(CLK_PER_BIT);

  logic          r_rx_meta;
  logic          r_rx_s;
  logic          r_rx_prev;
  logic [PW-1:0] r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= RECESSIVE;
      r_rx_s    <= RECESSIVE;
      r_rx_prev <= RECESSIVE;
      r_phase   <= '0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      if (i_resync)
        r_phase <= PW'(1);
      else if (r_phase == PW'(CLK_PER_BIT - 1))
        r_phase <= '0;
      else
        r_phase <= r_phase + PW'(1);
    end
  end

  assign o_rx_s   = r_rx_s;
  assign o_edge   = r_rx_prev & ~r_rx_s;
  assign o_sample = (r_phase == PW'(SAMPLE_PT));

endmodule

// File: rtl/can_capture_ctrl.sv
// CAN capture sequencer: idle/SOF detection, de-stuffing, capture-block
// strobes, stuff/overrun error and end-of-frame detection.
module can_capture_ctrl
  import can_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 16,
  parameter int unsigned SAMPLE_PT   = 11,
  parameter int unsigned IDLE_BITS   = 11,
  parameter int unsigned STUFF_LEN   = STUFF_LEN_DEF,
  parameter int unsigned MAX_BITS    = 160
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_enable,
  output logic       o_cap_rst,
  output logic       o_cap_en,
  output logic       o_cap_bit,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_stuff_err,
  output logic [7:0] o_bit_count
);

  state_t     r_state, w_state;
  logic [7:0] r_idle_cnt, w_idle_cnt;
  logic [7:0] r_run, w_run;
  logic       r_last, w_last;
  logic [3:0] r_tail_cnt, w_tail_cnt;
  logic       r_skip, w_skip;
  logic [7:0] r_bit_count, w_bit_count;
  logic       r_cap_rst, w_cap_rst;
  logic       r_cap_en, w_cap_en;
  logic       r_cap_bit, w_cap_bit;
  logic       r_busy, w_busy;
  logic       r_frame_done, w_frame_done;
  logic       r_stuff_err, w_stuff_err;
  logic       w_rx_s, w_edge, w_sample, w_resync;
  logic [7:0] w_fwd_count;

  can_bit_timing #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .SAMPLE_PT  (SAMPLE_PT)
  ) u_bit_timing (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_rx),
    .i_resync(w_resync),
    .o_rx_s  (w_rx_s),
    .o_edge  (w_edge),
    .o_sample(w_sample)
  );

  always_comb begin
    w_state      = r_state;
    w_idle_cnt   = r_idle_cnt;
    w_run        = r_run;
    w_last       = r_last;
    w_tail_cnt   = r_tail_cnt;
    w_skip       = r_skip;
    w_bit_count  = r_bit_count;
    w_cap_bit    = r_cap_bit;
    w_cap_rst    = 1'b0;
    w_cap_en     = 1'b0;
    w_frame_done = 1'b0;
    w_stuff_err  = 1'b0;
    w_resync     = 1'b0;
    w_fwd_count  = sat_inc8(r_bit_count);

    if (!i_enable) begin
      w_state    = IDLE_WAIT;
      w_idle_cnt = '0;
      w_run      = '0;
      w_last     = DOMINANT;
      w_tail_cnt = '0;
      w_skip     = 1'b0;
    end else begin
      unique case (r_state)
        IDLE_WAIT, ERROR: begin
          if (w_sample) begin
            if (w_rx_s == RECESSIVE) begin
              if (r_idle_cnt == 8'(IDLE_BITS - 1)) begin
                w_state    = IDLE;
                w_idle_cnt = '0;
              end else begin
                w_idle_cnt = r_idle_cnt + 8'd1;
              end
            end else begin
              w_idle_cnt = '0;
            end
          end
        end
        IDLE: begin
          if (w_edge) begin
            w_resync    = 1'b1;
            w_cap_rst   = 1'b1;
            w_bit_count = '0;
            w_run       = 8'd1;
            w_last      = DOMINANT;
            w_skip      = 1'b1;
            w_state     = RECEIVE;
          end
        end
        RECEIVE: begin
          if (w_sample) begin
            // Hard sync lands the first sample inside SOF itself; SOF is
            // already accounted for in run/last, so that sample is dropped.
            if (r_skip) begin
              w_skip = 1'b0;
            end else if (r_run == 8'(STUFF_LEN)) begin
              if (w_rx_s != r_last) begin
                w_run  = 8'd1;
                w_last = w_rx_s;
              end else if (r_last == DOMINANT) begin
                w_stuff_err = 1'b1;
                w_state     = ERROR;
              end else begin
                w_tail_cnt = 4'(EOF_LEN - 1);
                w_state    = TAIL;
              end
            end else begin
              w_cap_en    = 1'b1;
              w_cap_bit   = w_rx_s;
              w_bit_count = w_fwd_count;
              w_run       = (w_rx_s == r_last) ? r_run + 8'd1 : 8'd1;
              w_last      = w_rx_s;
              if (w_fwd_count == 8'(MAX_BITS)) begin
                w_stuff_err = 1'b1;
                w_state     = ERROR;
              end
            end
          end else if (w_edge) begin
            w_resync = 1'b1;
          end
        end
        TAIL: begin
          if (w_sample) begin
            if (w_rx_s == RECESSIVE) begin
              if (r_tail_cnt == 4'(EOF_LEN - 1)) begin
                w_frame_done = 1'b1;
                w_state      = IDLE;
              end else begin
                w_tail_cnt = r_tail_cnt + 4'd1;
              end
            end else begin
              w_stuff_err = 1'b1;
              w_state     = ERROR;
            end
          end
        end
        default: w_state = IDLE_WAIT;
      endcase
    end

    w_busy = (w_state == RECEIVE) || (w_state == TAIL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE_WAIT;
      r_idle_cnt   <= '0;
      r_run        <= '0;
      r_last       <= DOMINANT;
      r_tail_cnt   <= '0;
      r_skip       <= 1'b0;
      r_bit_count  <= '0;
      r_cap_rst    <= 1'b0;
      r_cap_en     <= 1'b0;
      r_cap_bit    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idle_cnt   <= w_idle_cnt;
      r_run        <= w_run;
      r_last       <= w_last;
      r_tail_cnt   <= w_tail_cnt;
      r_skip       <= w_skip;
      r_bit_count  <= w_bit_count;
      r_cap_rst    <= w_cap_rst;
      r_cap_en     <= w_cap_en;
      r_cap_bit    <= w_cap_bit;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      r_stuff_err  <= w_stuff_err;
    end
  end

  assign o_cap_rst    = r_cap_rst;
  assign o_cap_en     = r_cap_en;
  assign o_cap_bit    = r_cap_bit;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_stuff_err  = r_stuff_err;
  assign o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_can_capture_ctrl.sv
// Directed bench for can_capture_ctrl: pulse counters sampled on the falling
// clock edge, checked against hand-derived totals at each step.
module tb_can_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       enable;
  logic       cap_rst, cap_en, cap_bit, busy, frame_done, stuff_err;
  logic [7:0] bit_count;

  int unsigned  n_cmp  = 0;
  int unsigned  n_fail = 0;
  int unsigned  n_rst_p = 0, n_en = 0, n_done = 0, n_err = 0, n_excl = 0;
  logic [255:0] capv = '0;

  can_capture_ctrl #(
    .CLK_PER_BIT(16),
    .SAMPLE_PT  (11),
    .IDLE_BITS  (11),
    .STUFF_LEN  (5),
    .MAX_BITS   (160)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .i_enable    (enable),
    .o_cap_rst   (cap_rst),
    .o_cap_en    (cap_en),
    .o_cap_bit   (cap_bit),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_stuff_err (stuff_err),
    .o_bit_count (bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_rst) n_rst_p++;
    if (cap_en) begin
      n_en++;
      capv = {capv[254:0], cap_bit};
    end
    if (frame_done) n_done++;
    if (stuff_err) n_err++;
    if ((cap_rst && cap_en) || (frame_done && stuff_err)) n_excl++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bits(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cap_rst, cap_en, cap_bit, busy, frame_done, stuff_err, bit_count}, 0);
    rst_n = 1'b1;

    // Only 10 recessive bits before a dominant bit: no SOF accepted
    bits(1'b1, 160);
    bits(1'b0, 32);
    check("early_edge_no_sof", n_rst_p, 0);
    bits(1'b1, 192);
    bits(1'b0, 16);
    check("sof_cap_rst", n_rst_p, 1);
    check("sof_busy", busy, 1);

    // 0,0,0,0 then stuff 1 then 0
    for (int i = 0; i < 4; i++) bits(1'b0, 16);
    bits(1'b1, 16);
    bits(1'b0, 16);
    check("stuff_en_count", n_en, 5);
    check("stuff_bit_count", bit_count, 5);
    check("stuff_bits", capv[4:0], 5'b00000);

    // Five forwarded recessive bits, sixth enters the tail
    bits(1'b1, 96);
    check("tail_busy", busy, 1);
    check("tail_no_done", n_done, 0);
    check("tail_en_count", n_en, 10);
    bits(1'b1, 16);
    check("eof_done", n_done, 1);
    check("eof_busy", busy, 0);
    check("eof_bit_count", bit_count, 10);
    check("eof_bits", capv[9:0], 10'b0000011111);
    check("eof_no_err", n_err, 0);

    // Next edge after frame gives a new SOF
    bits(1'b1, 32);
    bits(1'b0, 16);
    check("sof2_cap_rst", n_rst_p, 2);
    check("sof2_bit_count_clr", bit_count, 0);

    // Six dominant samples including SOF -> stuff error
    for (int i = 0; i < 5; i++) bits(1'b0, 16);
    check("stuff6_err", n_err, 1);
    check("stuff6_busy", busy, 0);
    check("stuff6_en_count", n_en, 14);
    check("stuff6_bit_count", bit_count, 4);
    bits(1'b0, 32);
    bits(1'b1, 80);
    bits(1'b0, 16);
    check("err_no_early_rearm", n_rst_p, 2);
    bits(1'b1, 192);

    // Drifting bit rate (19 clk bits), resynced on each falling edge
    bits(1'b0, 19);
    check("sof3_cap_rst", n_rst_p, 3);
    bits(1'b1, 19); bits(1'b0, 19); bits(1'b1, 19); bits(1'b1, 19);
    bits(1'b0, 19); bits(1'b0, 19); bits(1'b1, 19); bits(1'b0, 19);
    bits(1'b1, 112);
    check("drift_bits", capv[12:0], 13'b1011001011111);
    check("drift_en_count", n_en, 27);
    check("drift_done", n_done, 2);
    check("drift_bit_count", bit_count, 13);

    // Reset in the middle of a 40-bit frame
    bits(1'b1, 32);
    bits(1'b0, 16);
    check("sof4_cap_rst", n_rst_p, 4);
    for (int i = 0; i < 40; i++) bits((i % 2 == 0) ? 1'b1 : 1'b0, 16);
    check("pre_reset_bit_count", bit_count, 40);
    check("pre_reset_busy", busy, 1);
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {cap_rst, cap_en, cap_bit, busy, frame_done, stuff_err, bit_count}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_no_pulse", n_en, 67);
    bits(1'b1, 80);
    bits(1'b0, 16);
    check("post_reset_no_sof", n_rst_p, 4);
    bits(1'b1, 192);
    bits(1'b0, 16);
    check("post_reset_sof", n_rst_p, 5);

    // MAX_BITS overrun on the 160th forwarded bit
    for (int i = 0; i < 159; i++) bits((i % 2 == 0) ? 1'b1 : 1'b0, 16);
    check("max159_no_err", n_err, 1);
    check("max159_bit_count", bit_count, 159);
    bits(1'b0, 16);
    check("max160_err", n_err, 2);
    check("max160_bit_count", bit_count, 160);
    check("max160_busy", busy, 0);
    check("max160_en_count", n_en, 227);

    // enable=0 blocks SOF and forces re-qualification of idle
    bits(1'b1, 192);
    enable = 1'b0;
    bits(1'b0, 16);
    bits(1'b1, 16);
    enable = 1'b1;
    bits(1'b1, 32);
    bits(1'b0, 16);
    check("disabled_no_sof", n_rst_p, 5);
    bits(1'b1, 192);
    bits(1'b0, 16);
    check("reenabled_sof", n_rst_p, 6);
    bits(1'b1, 16);

    check("exclusive_pulses", n_excl, 0);
    check("final_done_count", n_done, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
